// File: rtl/lvds_rx_pkg.sv
// rtl/lvds_rx_pkg.sv - shared FSM encoding and constants for the LVDS receive aligner controller
package lvds_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_SETTLE    = 3'd2,
    ST_WAIT_LOCK = 3'd3,
    ST_CHECK     = 3'd4,
    ST_NEXT_TAP  = 3'd5,
    ST_NEXT_CH   = 3'd6,
    ST_MONITOR   = 3'd7
  } align_state_e;

  localparam int               WORD_W          = 7;
  localparam logic [WORD_W-1:0] CLK_PATTERN_DEF = 7'b1100011;
  localparam int               MISMATCH_LIMIT  = 4;

endpackage

// File: rtl/lvds_rx_lock_check.sv
// rtl/lvds_rx_lock_check.sv - per-channel clock-word match counter plus mismatch watchdog
// The watchdog exists only when LVDS_ALIGN_CTRL_MONITOR_EN is defined.
module lvds_rx_lock_check
  import lvds_rx_pkg::*;
#(
  parameter int                STABLE_CNT  = 64,
  parameter logic [WORD_W-1:0] CLK_PATTERN = CLK_PATTERN_DEF
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic              mon_en_i,
  input  logic              valid_i,
  input  logic [WORD_W-1:0] data_i,
  output logic              match_o,
  output logic              stable_o,
  output logic              trip_o
);

  localparam int MCNT_W = $clog2(STABLE_CNT + 1);

  logic [MCNT_W-1:0] mcnt_q, mcnt_d;
  logic              word_ok;

  assign word_ok  = valid_i && (data_i == CLK_PATTERN);
  assign match_o  = word_ok;
  assign stable_o = en_i && word_ok && (mcnt_q == MCNT_W'(STABLE_CNT - 1));

  // Any bad or missing word while counting restarts the run from zero.
  always_comb begin
    mcnt_d = mcnt_q;
    if (clr_i) begin
      mcnt_d = '0;
    end else if (en_i) begin
      mcnt_d = (word_ok && !stable_o) ? mcnt_q + 1'b1 : '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      mcnt_q <= '0;
    end else begin
      mcnt_q <= mcnt_d;
    end
  end

`ifdef LVDS_ALIGN_CTRL_MONITOR_EN
  localparam int MIS_W = $clog2(MISMATCH_LIMIT + 1);

  logic [MIS_W-1:0] mis_q, mis_d;
  logic             word_bad;

  assign word_bad = valid_i && (data_i != CLK_PATTERN);
  assign trip_o   = mon_en_i && word_bad && (mis_q == MIS_W'(MISMATCH_LIMIT - 1));

  // Invalid cycles neither extend nor break a run of bad words.
  always_comb begin
    mis_d = mis_q;
    if (!mon_en_i || trip_o) begin
      mis_d = '0;
    end else if (word_bad) begin
      mis_d = mis_q + 1'b1;
    end else if (word_ok) begin
      mis_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      mis_q <= '0;
    end else begin
      mis_q <= mis_d;
    end
  end
`else
  logic unused_mon;
  assign unused_mon = mon_en_i;
  assign trip_o     = 1'b0;
`endif

endmodule

// File: rtl/lvds_rx_align_ctrl.sv
// rtl/lvds_rx_align_ctrl.sv - two-channel delay-tap scan and lock controller for LVDS word aligners
// Optional lock-loss restart in MONITOR is enabled by LVDS_ALIGN_CTRL_MONITOR_EN.
module lvds_rx_align_ctrl
  import lvds_rx_pkg::*;
#(
  parameter int                TAP_W       = 5,
  parameter int                SETTLE_CYC  = 16,
  parameter int                LOCK_TMO    = 1024,
  parameter int                STABLE_CNT  = 64,
  parameter logic [WORD_W-1:0] CLK_PATTERN = CLK_PATTERN_DEF
) (
  input  logic              I_clk,
  input  logic              I_rst_n,
  input  logic [1:0]        I_align_valid,
  input  logic [WORD_W-1:0] I_align_data0,
  input  logic [WORD_W-1:0] I_align_data1,
  output logic [1:0]        O_idelay_done,
  output logic [1:0]        O_align_rst,
  output logic              O_tap_load,
  output logic              O_tap_ch,
  output logic [TAP_W-1:0]  O_tap_val,
  output logic [1:0]        O_link_up,
  output logic [1:0]        O_fail
);

  localparam int               CNT_MAX  = (LOCK_TMO > SETTLE_CYC) ? LOCK_TMO : SETTLE_CYC;
  localparam int               CNT_W    = $clog2(CNT_MAX + 1);
  localparam logic [TAP_W-1:0] TAP_LAST = {TAP_W{1'b1}};

  align_state_e     state_q, state_d;
  logic             ch_q, ch_d;
  logic [TAP_W-1:0] tap_q, tap_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       todo_q, todo_d;

  logic [1:0]       idelay_done_q, idelay_done_d;
  logic [1:0]       align_rst_q, align_rst_d;
  logic             tap_load_q, tap_load_d;
  logic             tap_ch_q, tap_ch_d;
  logic [TAP_W-1:0] tap_val_q, tap_val_d;
  logic [1:0]       link_up_q, link_up_d;
  logic [1:0]       fail_q, fail_d;

  logic [1:0] match_vec, stable_vec, trip_vec;
  logic [1:0] chk_en, chk_clr, mon_en;
  logic [1:0] ch_sel, todo_rem;
  logic       tap_last;

  assign ch_sel   = ch_q ? 2'b10 : 2'b01;
  assign tap_last = (tap_q == TAP_LAST);
  assign todo_rem = todo_q & ~ch_sel;
  assign chk_en   = (state_q == ST_CHECK) ? ch_sel : 2'b00;
  assign chk_clr  = (state_q == ST_LOAD) ? ch_sel : 2'b00;
  assign mon_en   = (state_q == ST_MONITOR) ? link_up_q : 2'b00;

  lvds_rx_lock_check #(
    .STABLE_CNT (STABLE_CNT),
    .CLK_PATTERN(CLK_PATTERN)
  ) u_chk0 (
    .clk_i   (I_clk),
    .rst_n_i (I_rst_n),
    .clr_i   (chk_clr[0]),
    .en_i    (chk_en[0]),
    .mon_en_i(mon_en[0]),
    .valid_i (I_align_valid[0]),
    .data_i  (I_align_data0),
    .match_o (match_vec[0]),
    .stable_o(stable_vec[0]),
    .trip_o  (trip_vec[0])
  );

  lvds_rx_lock_check #(
    .STABLE_CNT (STABLE_CNT),
    .CLK_PATTERN(CLK_PATTERN)
  ) u_chk1 (
    .clk_i   (I_clk),
    .rst_n_i (I_rst_n),
    .clr_i   (chk_clr[1]),
    .en_i    (chk_en[1]),
    .mon_en_i(mon_en[1]),
    .valid_i (I_align_valid[1]),
    .data_i  (I_align_data1),
    .match_o (match_vec[1]),
    .stable_o(stable_vec[1]),
    .trip_o  (trip_vec[1])
  );

  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      state_q       <= ST_IDLE;
      ch_q          <= 1'b0;
      tap_q         <= '0;
      cnt_q         <= '0;
      todo_q        <= 2'b00;
      idelay_done_q <= 2'b00;
      align_rst_q   <= 2'b00;
      tap_load_q    <= 1'b0;
      tap_ch_q      <= 1'b0;
      tap_val_q     <= '0;
      link_up_q     <= 2'b00;
      fail_q        <= 2'b00;
    end else begin
      state_q       <= state_d;
      ch_q          <= ch_d;
      tap_q         <= tap_d;
      cnt_q         <= cnt_d;
      todo_q        <= todo_d;
      idelay_done_q <= idelay_done_d;
      align_rst_q   <= align_rst_d;
      tap_load_q    <= tap_load_d;
      tap_ch_q      <= tap_ch_d;
      tap_val_q     <= tap_val_d;
      link_up_q     <= link_up_d;
      fail_q        <= fail_d;
    end
  end

  // todo_q holds the channels still owed a scan, so a restart from MONITOR only touches tripped ones.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    tap_d   = tap_q;
    cnt_d   = cnt_q;
    todo_d  = todo_q;
    case (state_q)
      ST_IDLE: begin
        ch_d    = 1'b0;
        tap_d   = '0;
        cnt_d   = '0;
        todo_d  = 2'b11;
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        cnt_d   = '0;
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
          cnt_d   = '0;
          state_d = ST_WAIT_LOCK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT_LOCK: begin
        if (I_align_valid[ch_q]) begin
          cnt_d   = '0;
          state_d = ST_CHECK;
        end else if (cnt_q == CNT_W'(LOCK_TMO - 1)) begin
          cnt_d   = '0;
          state_d = ST_NEXT_TAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_CHECK: begin
        if (stable_vec[ch_q]) begin
          state_d = ST_NEXT_CH;
        end else if (!match_vec[ch_q]) begin
          state_d = ST_NEXT_TAP;
        end
      end
      ST_NEXT_TAP: begin
        if (tap_last) begin
          state_d = ST_NEXT_CH;
        end else begin
          tap_d   = tap_q + 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_NEXT_CH: begin
        todo_d = todo_rem;
        tap_d  = '0;
        if (todo_rem[0]) begin
          ch_d    = 1'b0;
          state_d = ST_LOAD;
        end else if (todo_rem[1]) begin
          ch_d    = 1'b1;
          state_d = ST_LOAD;
        end else begin
          state_d = ST_MONITOR;
        end
      end
      ST_MONITOR: begin
        if (trip_vec != 2'b00) begin
          todo_d  = trip_vec;
          ch_d    = !trip_vec[0];
          tap_d   = '0;
          state_d = ST_LOAD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are computed from the next state so every port is a flop aligned with state_q.
  always_comb begin
    tap_load_d    = (state_d == ST_LOAD);
    tap_ch_d      = tap_load_d ? ch_d : 1'b0;
    tap_val_d     = tap_load_d ? tap_d : '0;
    align_rst_d   = tap_load_d ? (ch_d ? 2'b10 : 2'b01) : 2'b00;
    idelay_done_d = idelay_done_q;
    link_up_d     = link_up_q & ~trip_vec;
    fail_d        = fail_q;
    if (tap_load_d) begin
      idelay_done_d = idelay_done_q & ~align_rst_d;
    end
    if (state_q == ST_SETTLE && state_d == ST_WAIT_LOCK) begin
      idelay_done_d = idelay_done_q | ch_sel;
    end
    if (state_q == ST_CHECK && stable_vec[ch_q]) begin
      link_up_d = link_up_q | ch_sel;
    end
    if (state_q == ST_NEXT_TAP && tap_last) begin
      fail_d        = fail_q | ch_sel;
      idelay_done_d = idelay_done_q & ~ch_sel;
    end
  end

  assign O_idelay_done = idelay_done_q;
  assign O_align_rst   = align_rst_q;
  assign O_tap_load    = tap_load_q;
  assign O_tap_ch      = tap_ch_q;
  assign O_tap_val     = tap_val_q;
  assign O_link_up     = link_up_q;
  assign O_fail        = fail_q;

endmodule

// File: doc/lvds_rx_align_ctrl.md
LVDS_RX_ALIGN_CTRL -- requirements
Module: lvds_rx_align_ctrl

Interface
REQ-001 SHALL have parameter TAP_W, default 5, meaning delay-tap code width.
REQ-002 SHALL have parameter SETTLE_CYC, default 16, meaning idle cycles after a tap load before alignment starts.
REQ-003 SHALL have parameter LOCK_TMO, default 1024, meaning the cycle limit for the aligner to report valid.
REQ-004 SHALL have parameter STABLE_CNT, default 64, meaning consecutive correct clock-lane words required to declare lock.
REQ-005 SHALL have parameter CLK_PATTERN, default 7'b1100011, meaning the expected aligned clock-lane word.
REQ-006 SHALL have port I_clk, in, 1 bit: sole clock.
REQ-007 SHALL have port I_rst_n, in, 1 bit: reset, synchronous to I_clk, active-low.
REQ-008 SHALL have port I_align_valid, in, 2 bits: per-channel aligner valid.
REQ-009 SHALL have ports I_align_data0 and I_align_data1, in, 7 bits each: aligned clock-lane word for channel 0 and channel 1.
REQ-010 SHALL have port O_idelay_done, out, 2 bits: per-channel enable to the aligner; 0 holds the aligner shift register cleared.
REQ-011 SHALL have port O_align_rst, out, 2 bits: per-channel one-cycle aligner reset pulse.
REQ-012 SHALL have ports O_tap_load (out, 1: one-cycle load strobe), O_tap_ch (out, 1: target channel) and O_tap_val (out, TAP_W: tap code) forming the shared delay-load port.
REQ-013 SHALL have ports O_link_up (out, 2: channel locked) and O_fail (out, 2: all taps exhausted).

Function
REQ-014 SHALL serve one channel at a time through an FSM: IDLE, LOAD, SETTLE, WAIT_LOCK, CHECK, NEXT_TAP, NEXT_CH, MONITOR.
REQ-015 IDLE SHALL select channel 0 with tap 0 and go to LOAD on the next cycle.
REQ-016 LOAD SHALL last exactly 1 cycle: O_tap_load=1, O_tap_ch=current channel, O_tap_val=current tap, O_align_rst[ch]=1, O_idelay_done[ch]=0; it then goes to SETTLE.
REQ-017 SETTLE SHALL hold O_idelay_done[ch]=0 for exactly SETTLE_CYC cycles and then go to WAIT_LOCK with O_idelay_done[ch]=1.
REQ-018 WAIT_LOCK SHALL go to CHECK on the first cycle I_align_valid[ch]=1, and SHALL go to NEXT_TAP when LOCK_TMO cycles have elapsed without valid.
REQ-019 CHECK SHALL count consecutive cycles where the channel word equals CLK_PATTERN; a mismatch or loss of valid SHALL go to NEXT_TAP; STABLE_CNT matches SHALL set O_link_up[ch]=1 and go to NEXT_CH.
REQ-020 NEXT_TAP SHALL increment the tap and go to LOAD; at tap 2^TAP_W-1 it SHALL instead set O_fail[ch]=1, keep O_idelay_done[ch]=0, and go to NEXT_CH (no wrap-around).
REQ-021 NEXT_CH SHALL go to LOAD for channel 1 with tap 0 if channel 0 was just served, otherwise to MONITOR.
REQ-022 O_tap_load SHALL pulse only in LOAD; it SHALL never be asserted for both channels in one cycle.
REQ-023 Outputs SHALL be registered; O_link_up SHALL rise 1 cycle after the STABLE_CNT-th matching word.

Reset
REQ-024 When I_rst_n=0 at a clock edge, the block SHALL enter IDLE with all outputs 0, tap 0, and counters 0, including mid-scan; O_link_up and O_fail SHALL clear.

Configuration
REQ-025 With LVDS_ALIGN_CTRL_MONITOR_EN defined, MONITOR SHALL count consecutive CLK_PATTERN mismatches per locked channel; at 4 it SHALL clear O_link_up[ch] and restart that channel at LOAD with tap 0; if both channels trip in the same cycle, channel 0 SHALL be served first and channel 1 next.
REQ-026 Without LVDS_ALIGN_CTRL_MONITOR_EN, MONITOR SHALL be terminal: O_link_up and O_fail hold until reset, and no mismatch logic is synthesised.

Structure
REQ-027 The FSM state encoding, the CLK_PATTERN default and the mismatch limit 4 SHALL live in shared package lvds_rx_pkg.
REQ-028 One sub-module, lvds_rx_lock_check (per-channel pattern-match counter plus mismatch counter), SHALL be instantiated twice.

Verification
REQ-029 Both channels present CLK_PATTERN after a tap-3 load -> tap loads 0..3 on each channel, O_link_up=2'b11, O_fail=0.
REQ-030 Channel 0 valid never rises -> after LOCK_TMO cycles per tap, 32 taps are tried, O_fail[0]=1, and channel 1 still locks.
REQ-031 Channel 1 mismatches at the 63rd word of CHECK -> tap increments, and the match count restarts from 0.
REQ-032 MONITOR_EN set, 4 mismatches on channel 1 after lock -> O_link_up[1]=0 on the next cycle, LOAD for ch1 at tap 0, and channel 0 is unaffected.
REQ-033 I_rst_n=0 for 1 cycle during SETTLE -> all outputs 0 on the next cycle, and the scan restarts at channel 0 with tap 0.
